fmap_burst_reader: RTL
======================

// Module: fmap_burst_reader
// PURPOSE
//  Upstream feeder of the feature-map width converter. Walks a 2-D feature-map tile in on-chip memory
//  (num_rows rows of row_groups*NUM_IN 256-bit words, rows row_stride words apart) and streams the words as
//  data_out/valid_out. Every row is a whole number of NUM_IN-word groups, so the converter's 9-in/8-out
//  framing stays aligned. No downstream backpressure; throughput is throttled only by hold.
// PARAMETERS
//  DATA_W   256  memory word / output width
//  ADDR_W   12   memory word-address width
//  NUM_IN   9    words per converter group
//  GRP_W    8    width of row_groups
//  ROW_W    10   width of num_rows
//  RD_LAT   2    memory read latency: rd_en at cycle t -> mem_rd_data valid at cycle t+RD_LAT (1..4)
// PORTS
//  sys_clk      in   1        single clock for the block
//  rst          in   1        asynchronous, active-high reset
//  start        in   1        1-cycle pulse; accepted only in IDLE
//  base_addr    in   ADDR_W   first word address of row 0; sampled at start
//  row_groups   in   GRP_W    NUM_IN-word groups per row; sampled at start
//  num_rows     in   ROW_W    rows in the tile; sampled at start
//  row_stride   in   ADDR_W   address step between row starts; sampled at start
//  hold         in   1        1 = issue no new read this cycle
//  mem_rd_en    out  1        memory read strobe
//  mem_rd_addr  out  ADDR_W   memory read address
//  mem_rd_data  in   DATA_W   memory read data
//  data_out     out  DATA_W   streamed word (to converter data_in)
//  valid_out    out  1        data_out qualifier (to converter valid_in)
//  last_out     out  1        high with the final word of the tile
//  busy         out  1        high from start acceptance to the done pulse, inclusive
//  done         out  1        1-cycle pulse after the final word has been output
//  cfg_err      out  1        1-cycle pulse: start rejected for a zero-sized tile
// BEHAVIOUR
//  - Reset: every output is 0 and the FSM is IDLE; all counters and the latency pipe are cleared.
//  - FSM states: IDLE, RUN, DRAIN, DONE.
//  - IDLE:
//      start with row_groups==0 or num_rows==0 -> cfg_err=1 for 1 cycle, no reads, stay IDLE.
//      Otherwise latch the config, row_base=base_addr, word=0, grp=0, row=0, and go to RUN.
//      busy rises on the next cycle.
//  - RUN: each cycle with hold==0, issue mem_rd_en=1, mem_rd_addr=row_base+grp*NUM_IN+word, then advance:
//      word wraps NUM_IN-1 -> 0 and increments grp;
//      grp wraps at row_groups-1 and increments row, with row_base += row_stride;
//      the read for (row=num_rows-1, grp=row_groups-1, word=NUM_IN-1) goes to DRAIN.
//  - hold==1 means mem_rd_en=0 and counters frozen. In-flight reads still complete, so valid_out may gap.
//    The converter tolerates gaps. hold is ignored outside RUN.
//  - Datapath latency: mem_rd_en at cycle t -> valid_out=1 and data_out=registered mem_rd_data at
//    cycle t+RD_LAT+1. A valid/last delay line of depth RD_LAT+1 tracks in-flight reads.
//  - last_out is tagged on the final read issued and travels with it through the delay line.
//  - DRAIN: no reads. Leave to DONE on the cycle the last-tagged word is on valid_out.
//  - DONE: done=1 for 1 cycle, busy drops the same cycle, next state IDLE. start in the DONE cycle is ignored.
//  - start while busy is ignored; config inputs are don't-care outside the start cycle.
//  - Address arithmetic is modulo 2^ADDR_W; wrap-around is legal and silent.
//  - Total words output = row_groups*NUM_IN*num_rows, exactly; always a multiple of NUM_IN.
//  - Reset mid-tile: everything is cleared immediately and the tile is abandoned. After reset deasserts
//    the converter must also be reset, because its group phase may be mid-group.
// STRUCTURE
//  - Shared package fmap_rd_pkg: FSM state encoding (IDLE/RUN/DRAIN/DONE) plus the NUM_IN and RD_LAT
//    defaults, so the converter and reader agree.
//  - Sub-module fmap_rd_lat_pipe: parameterised RD_LAT+1 shift register for {valid,last} with async reset.
//  - The top level holds the FSM, the word/grp/row counters, row_base and the output data register.
// TESTING
//  1. Reset, then base=0x010, groups=1, rows=1, stride=0, hold=0, start.
//     Expect 9 reads at 0x010..0x018 on consecutive cycles and 9 consecutive valid_out beats RD_LAT+1
//     later. last_out on beat 9, done the cycle after, busy high throughout.
//  2. groups=2, rows=3, base=0x100, stride=0x040.
//     Expect address runs 0x100-0x111, 0x140-0x151, 0x180-0x191 and 54 beats, with data equal to the
//     memory model contents.
//  3. Same tile as scenario 2 with hold pseudo-random at 50%.
//     Expect the same 54 words in order, no mem_rd_en while hold=1, and last_out/done exactly once.
//  4. start with rows=0, then with groups=0.
//     Expect cfg_err pulse, no mem_rd_en, busy=0. A further start pulse while a tile is running has no effect.
//  5. base=0xFFC, groups=1, rows=1.
//     Expect addresses 0xFFC..0xFFF then 0x000..0x004 (ADDR_W=12 wrap).
//  6. Assert rst during beat 20 of scenario 2.
//     Expect all outputs 0 in the same cycle. A fresh scenario-1 start afterwards completes normally.

Source files
------------

// File: rtl/fmap_rd_pkg.sv
// Shared definitions for the feature-map reader and its downstream converter:
// FSM encoding and the group size / read latency both sides must agree on.
package fmap_rd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } rd_state_t;

  localparam int NUM_IN_DEF = 9;
  localparam int RD_LAT_DEF = 2;

endpackage

// File: rtl/fmap_burst_reader_if.sv
// Memory read port plus output word stream of the feature-map burst reader.
interface fmap_burst_reader_if #(
  parameter int DATA_W = 256,
  parameter int ADDR_W = 12
);

  // Handshake: there is no ready anywhere. mem_rd_en issues one read whose
  // data the memory returns a fixed latency later; valid_out qualifies
  // data_out/last_out for exactly one cycle and the sink must accept it.
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic              last_out;

  modport master (
    output mem_rd_en,
    output mem_rd_addr,
    input  mem_rd_data,
    output data_out,
    output valid_out,
    output last_out
  );

  modport slave (
    input  mem_rd_en,
    input  mem_rd_addr,
    output mem_rd_data,
    input  data_out,
    input  valid_out,
    input  last_out
  );

endinterface

// File: rtl/fmap_rd_lat_pipe.sv
// Delay line tracking in-flight reads as {valid,last} pairs; pre_valid marks
// the cycle the memory data is present so the top can register it.
module fmap_rd_lat_pipe #(
  parameter int DEPTH = 3
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic in_valid,
  input  logic in_last,
  output logic pre_valid,
  output logic out_valid,
  output logic out_last
);

  logic [DEPTH-1:0] valid_sr;
  logic [DEPTH-1:0] last_sr;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      valid_sr <= '0;
      last_sr  <= '0;
    end else begin
      valid_sr <= {valid_sr[DEPTH-2:0], in_valid};
      last_sr  <= {last_sr[DEPTH-2:0], in_valid & in_last};
    end
  end

  assign pre_valid = valid_sr[DEPTH-2];
  assign out_valid = valid_sr[DEPTH-1];
  assign out_last  = last_sr[DEPTH-1];

endmodule

// File: rtl/fmap_burst_reader.sv
// Walks a 2-D feature-map tile in on-chip memory and streams its words,
// row by row, as whole NUM_IN-word groups.
module fmap_burst_reader
  import fmap_rd_pkg::*;
#(
  parameter int DATA_W = 256,
  parameter int ADDR_W = 12,
  parameter int NUM_IN = NUM_IN_DEF,
  parameter int GRP_W  = 8,
  parameter int ROW_W  = 10,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [GRP_W-1:0]  row_groups,
  input  logic [ROW_W-1:0]  num_rows,
  input  logic [ADDR_W-1:0] row_stride,
  input  logic              hold,
  fmap_burst_reader_if.master bus,
  output logic              busy,
  output logic              done,
  output logic              cfg_err,
  output rd_state_t         state_dbg
);

  localparam int WORD_W = $clog2(NUM_IN);
  localparam int DEPTH  = RD_LAT + 1;

  rd_state_t         state;
  logic [GRP_W-1:0]  cfg_groups;
  logic [ROW_W-1:0]  cfg_rows;
  logic [ADDR_W-1:0] cfg_stride;
  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] rd_addr;
  logic [WORD_W-1:0] word_q;
  logic [GRP_W-1:0]  grp_q;
  logic [ROW_W-1:0]  row_q;
  logic [DATA_W-1:0] data_q;

  logic rd_fire, last_rd, word_end, grp_end, row_end;
  logic pre_valid, out_valid, out_last;

  assign rd_fire  = (state == ST_RUN) && !hold;
  assign word_end = (word_q == WORD_W'(NUM_IN - 1));
  assign grp_end  = (grp_q == (cfg_groups - GRP_W'(1)));
  assign row_end  = (row_q == (cfg_rows - ROW_W'(1)));
  assign last_rd  = rd_fire && word_end && grp_end && row_end;

  // A row is contiguous, so rd_addr simply increments and only jumps to
  // row_base + stride at a row boundary; word/grp/row just track position.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cfg_groups <= '0;
      cfg_rows   <= '0;
      cfg_stride <= '0;
      row_base   <= '0;
      rd_addr    <= '0;
      word_q     <= '0;
      grp_q      <= '0;
      row_q      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (row_groups == '0 || num_rows == '0) begin
              cfg_err <= 1'b1;
            end else begin
              cfg_groups <= row_groups;
              cfg_rows   <= num_rows;
              cfg_stride <= row_stride;
              row_base   <= base_addr;
              rd_addr    <= base_addr;
              word_q     <= '0;
              grp_q      <= '0;
              row_q      <= '0;
              busy       <= 1'b1;
              state      <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (rd_fire) begin
            if (!word_end) begin
              word_q  <= word_q + WORD_W'(1);
              rd_addr <= rd_addr + ADDR_W'(1);
            end else begin
              word_q <= '0;
              if (!grp_end) begin
                grp_q   <= grp_q + GRP_W'(1);
                rd_addr <= rd_addr + ADDR_W'(1);
              end else begin
                grp_q    <= '0;
                row_q    <= row_q + ROW_W'(1);
                row_base <= row_base + cfg_stride;
                rd_addr  <= row_base + cfg_stride;
              end
            end
            if (last_rd) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (out_valid && out_last) begin
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst)            data_q <= '0;
    else if (pre_valid) data_q <= bus.mem_rd_data;
  end

  fmap_rd_lat_pipe #(.DEPTH(DEPTH)) u_lat_pipe (
    .sys_clk   (sys_clk),
    .rst       (rst),
    .in_valid  (rd_fire),
    .in_last   (last_rd),
    .pre_valid (pre_valid),
    .out_valid (out_valid),
    .out_last  (out_last)
  );

  assign bus.mem_rd_en   = rd_fire;
  assign bus.mem_rd_addr = rd_addr;
  assign bus.data_out    = data_q;
  assign bus.valid_out   = out_valid;
  assign bus.last_out    = out_last;
  assign state_dbg       = state;

endmodule
